// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the blink-rate decoder and the LED flasher it pairs
// with.
//   - decoder FSM state encoding
//   - width of the speed index (IDX_W)
//   - default highest decodable index (MAX_IDX_DEFAULT), shared with the
//     flasher's speed range
// -----------------------------------------------------------------------------
package blink_pkg;

    localparam int IDX_W           = 5;
    localparam int MAX_IDX_DEFAULT = 29;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        MEAS = 2'd1,
        LOCK = 2'd2
    } blink_state_e;

endpackage : blink_pkg

// File: rtl/blink_edge_sync.sv
// -----------------------------------------------------------------------------
// blink_edge_sync
// Two-flop synchronizer for an asynchronous input, followed by a delayed copy
// of the synchronized level. The output pulses for one cycle on every rising
// or falling transition of the synchronized signal.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset; all flops clear to 0
//   d_i      in   asynchronous input
//   level_o  out  synchronized level (second synchronizer stage)
//   edge_o   out  one-cycle pulse on either edge of level_o
// -----------------------------------------------------------------------------
module blink_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync2_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
        end else begin
            sync1_q     <= d_i;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign edge_o  = sync2_q ^ sync2_dly_q;

endmodule : blink_edge_sync

// File: rtl/blink_rate_decoder.sv
// -----------------------------------------------------------------------------
// blink_rate_decoder
// Measures the half-period of a blink signal that toggles every 2^k cycles and
// recovers k. The measured half-period P is counted between consecutive edges
// (either polarity); speed_idx is the bit position of P's MSB and exact flags
// a power-of-two P. Repeated agreeing measurements declare lock; a silent input
// for 2^(MAX_IDX+1)-1 counts returns the decoder to SEEK.
//
// Optional feature macro: BLINK_DEC_EXACT_EN
//   defined   - only exact (power-of-two) measurements count toward lock; a
//               non-exact one clears the match count and drops lock
//   undefined - lock qualification compares speed_idx only
//
// Parameters
//   MAX_IDX   highest decodable index; sets counter width and timeout
//   LOCK_CNT  consecutive agreeing measurements needed for lock (2..15)
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   blink_in    in   asynchronous blink input
//   speed_idx   out  last decoded index (reset 0)
//   exact       out  last measured period was a power of two (reset 0)
//   meas_valid  out  one-cycle pulse when speed_idx/exact update (reset 0)
//   locked      out  high while in LOCK (reset 0)
//   idle        out  high while in SEEK (reset 1)
// -----------------------------------------------------------------------------
module blink_rate_decoder
    import blink_pkg::*;
#(
    parameter int MAX_IDX  = MAX_IDX_DEFAULT,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blink_in,
    output logic [IDX_W-1:0] speed_idx,
    output logic             exact,
    output logic             meas_valid,
    output logic             locked,
    output logic             idle
);

    localparam int CNT_W   = MAX_IDX + 2;
    localparam int MATCH_W = 4;
    // 2^(MAX_IDX+1)-1: the top counter bit stays clear so that an edge landing
    // on the timeout cycle still yields a representable period.
    localparam logic [CNT_W-1:0]   TIMEOUT  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [MATCH_W-1:0] LOCK_THR = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_MAX = '1;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detect
    // ------------------------------------------------------------------
    logic blink_level;
    logic blink_edge;

    blink_edge_sync u_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (blink_in),
        .level_o (blink_level),
        .edge_o  (blink_edge)
    );

    // ------------------------------------------------------------------
    // Half-period counter: cleared on the edge cycle, saturating otherwise
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (blink_edge) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_d_unused_guard: begin
                cnt_q <= cnt_d;
            end
        end
    end

    wire timeout_hit = (cnt_q == TIMEOUT);

    // ------------------------------------------------------------------
    // Period decode: MSB position and power-of-two check
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] period;
    logic [IDX_W-1:0] period_idx;
    logic             period_exact;
    logic [CNT_W-1:0] msb_hit;

    assign period       = cnt_q + CNT_W'(1);
    assign period_exact = $onehot(period);

    // msb_hit[i] marks bit i as set with all higher bits clear.
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_msb
        if (gi == CNT_W - 1) begin : g_top
            assign msb_hit[gi] = period[gi];
        end else begin : g_low
            assign msb_hit[gi] = period[gi] && (period[CNT_W-1:gi+1] == '0);
        end
    end

    always_comb begin
        period_idx = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (msb_hit[i]) begin
                period_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Match qualification
    // ------------------------------------------------------------------
    logic               meas_qualifies;
    logic               idx_same;
    logic [MATCH_W-1:0] match_q;
    logic [MATCH_W-1:0] match_d;
    logic               lock_reached;

`ifdef BLINK_DEC_EXACT_EN
    assign meas_qualifies = period_exact;
`else
    assign meas_qualifies = 1'b1;
`endif

    // Comparison is against the previously reported index, which survives
    // a timeout; after SEEK the match count is zero so either outcome gives 1.
    assign idx_same = (period_idx == speed_idx);

    always_comb begin
        match_d = '0;
        if (meas_qualifies) begin
            if (!idx_same) begin
                match_d = MATCH_W'(1);
            end else if (match_q != MATCH_MAX) begin
                match_d = match_q + MATCH_W'(1);
            end else begin
                match_d = match_q;
            end
        end
    end

    assign lock_reached = meas_qualifies && (match_d >= LOCK_THR);

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    blink_state_e state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEEK;
            match_q    <= '0;
            speed_idx  <= '0;
            exact      <= 1'b0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            idle       <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            if (blink_edge) begin
                // An edge beats a coincident timeout.
                case (state_q)
                    SEEK: begin
                        state_q <= MEAS;
                        match_q <= '0;
                        locked  <= 1'b0;
                        idle    <= 1'b0;
                    end
                    MEAS, LOCK: begin
                        meas_valid <= 1'b1;
                        speed_idx  <= period_idx;
                        exact      <= period_exact;
                        idle       <= 1'b0;
                        match_q    <= match_d;
                        if ((state_q == LOCK && meas_qualifies && idx_same) || lock_reached) begin
                            state_q <= LOCK;
                            locked  <= 1'b1;
                        end else begin
                            state_q <= MEAS;
                            locked  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= SEEK;
                        match_q <= '0;
                        locked  <= 1'b0;
                        idle    <= 1'b1;
                    end
                endcase
            end else if (timeout_hit) begin
                state_q <= SEEK;
                match_q <= '0;
                locked  <= 1'b0;
                idle    <= 1'b1;
            end
        end
    end

    // The synchronized level itself is not needed here; only its edges are.
    logic blink_level_unused;
    assign blink_level_unused = blink_level;

endmodule : blink_rate_decoder

// File: tb/tb_blink_rate_decoder.sv
// Self-checking bench for blink_rate_decoder (MAX_IDX=4, LOCK_CNT=3).
// A table of toggle events carries the expected measurement for each edge;
// expectations are queued when the toggle is driven and popped when the DUT
// pulses meas_valid.
module tb_blink_rate_decoder;

    logic       clk;
    logic       rst_n;
    logic       blink_in;
    logic [4:0] speed_idx;
    logic       exact;
    logic       meas_valid;
    logic       locked;
    logic       idle;

    int errors = 0;
    int checks = 0;

    blink_rate_decoder #(
        .MAX_IDX  (4),
        .LOCK_CNT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blink_in   (blink_in),
        .speed_idx  (speed_idx),
        .exact      (exact),
        .meas_valid (meas_valid),
        .locked     (locked),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gap;    // cycles since previous toggle / previous hand step
        bit meas;   // edge should produce a measurement
        int idx;
        bit ex;
        bit lk;
    } vec_t;

    typedef struct {
        int idx;
        bit ex;
        bit lk;
    } exp_t;

    vec_t tbl[24];
    exp_t sbq[$];
    bit   prev_mv = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input int g, input bit m, input int i, input bit e, input bit l);
        vec_t v;
        v.gap = g; v.meas = m; v.idx = i; v.ex = e; v.lk = l;
        return v;
    endfunction

    task automatic apply(input int lo, input int hi);
        exp_t e;
        for (int k = lo; k <= hi; k++) begin
            repeat (tbl[k].gap) @(negedge clk);
            blink_in = ~blink_in;
            if (tbl[k].meas) begin
                e.idx = tbl[k].idx; e.ex = tbl[k].ex; e.lk = tbl[k].lk;
                sbq.push_back(e);
            end
            $display("toggle %0d gap=%0d meas=%0d idx=%0d exact=%0d locked=%0d",
                     k, tbl[k].gap, tbl[k].meas, tbl[k].idx, tbl[k].ex, tbl[k].lk);
        end
    endtask

    // Scoreboard side: every meas_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_mv = 1'b0;
        end else begin
            if (meas_valid) begin
                chk("pulse_width", int'(prev_mv), 0);
                chk("meas_expected", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("speed_idx", int'(speed_idx), e.idx);
                    chk("exact", int'(exact), int'(e.ex));
                    chk("locked", int'(locked), int'(e.lk));
                    chk("idle_on_meas", int'(idle), 0);
                    $display("meas idx=%0d exact=%0d locked=%0d", speed_idx, exact, locked);
                end
            end
            prev_mv = meas_valid;
        end
    end

    initial begin
        // 8-cycle half-period from reset, lock on the 3rd measurement
        tbl[0]  = mk(5, 0, 0, 0, 0);
        tbl[1]  = mk(5, 1, 3, 1, 0);   // 3 cycles already spent in a hand check
        tbl[2]  = mk(8, 1, 3, 1, 0);
        tbl[3]  = mk(8, 1, 3, 1, 1);
        tbl[4]  = mk(8, 1, 3, 1, 1);
        // 32-cycle half-period: edge lands exactly on the timeout count
        tbl[5]  = mk(32, 1, 5, 1, 0);
        tbl[6]  = mk(32, 1, 5, 1, 0);
        tbl[7]  = mk(32, 1, 5, 1, 1);
        // back to 8
        tbl[8]  = mk(8, 1, 3, 1, 0);
        tbl[9]  = mk(8, 1, 3, 1, 0);
        tbl[10] = mk(8, 1, 3, 1, 1);
        // after timeout: first edge silent, then 12-cycle half-period
        tbl[11] = mk(3, 0, 0, 0, 0);
`ifdef BLINK_DEC_EXACT_EN
        tbl[12] = mk(12, 1, 3, 0, 0);
        tbl[13] = mk(12, 1, 3, 0, 0);
        tbl[14] = mk(12, 1, 3, 0, 0);
        tbl[15] = mk(12, 1, 3, 0, 0);
`else
        tbl[12] = mk(12, 1, 3, 0, 0);
        tbl[13] = mk(12, 1, 3, 0, 0);
        tbl[14] = mk(12, 1, 3, 0, 1);
        tbl[15] = mk(12, 1, 3, 0, 1);
`endif
        // after another timeout: relock at 8 before the reset test
        tbl[16] = mk(3, 0, 0, 0, 0);
        tbl[17] = mk(8, 1, 3, 1, 0);
        tbl[18] = mk(8, 1, 3, 1, 0);
        tbl[19] = mk(8, 1, 3, 1, 1);
        // recovery after reset
        tbl[20] = mk(5, 0, 0, 0, 0);
        tbl[21] = mk(8, 1, 3, 1, 0);
        tbl[22] = mk(8, 1, 3, 1, 0);
        tbl[23] = mk(8, 1, 3, 1, 1);

        rst_n    = 1'b0;
        blink_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_speed_idx", int'(speed_idx), 0);
        chk("rst_exact", int'(exact), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_idle", int'(idle), 1);
        rst_n = 1'b1;

        apply(0, 0);
        repeat (3) @(negedge clk);
        chk("idle_after_first_edge", int'(idle), 0);
        chk("locked_after_first_edge", int'(locked), 0);
        apply(1, 10);

        // Silence: LOCK holds through the timeout count, SEEK one cycle later.
        repeat (34) @(negedge clk);
        chk("pre_timeout_idle", int'(idle), 0);
        chk("pre_timeout_locked", int'(locked), 1);
        @(negedge clk);
        chk("timeout_idle", int'(idle), 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_speed_idx", int'(speed_idx), 3);
        chk("timeout_exact", int'(exact), 1);

        apply(11, 15);
        repeat (40) @(negedge clk);
        chk("timeout2_idle", int'(idle), 1);
        chk("timeout2_locked", int'(locked), 0);

        apply(16, 19);
        repeat (4) @(negedge clk);
        chk("queue_drained_pre_reset", sbq.size(), 0);
        chk("locked_pre_reset", int'(locked), 1);

        // Asynchronous reset mid-count, between clock edges.
        #3;
        rst_n    = 1'b0;
        blink_in = 1'b0;
        #1;
        chk("async_rst_speed_idx", int'(speed_idx), 0);
        chk("async_rst_exact", int'(exact), 0);
        chk("async_rst_meas_valid", int'(meas_valid), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_idle", int'(idle), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", int'(idle), 1);

        apply(20, 23);
        repeat (6) @(negedge clk);
        chk("final_locked", int'(locked), 1);
        chk("queue_drained_final", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_blink_rate_decoder
